// File: rtl/cache_fill_fsm.sv
// Cache block fill controller: on a miss, streams eight word reads to memory,
// writes each returned word into the data array, then writes the tag once.
module cache_fill_fsm #(
    parameter int WORDS   = 8,
    parameter int MEM_LAT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        miss_detected,
    input  logic [15:0] miss_address,
    input  logic [15:0] memory_data,
    input  logic        memory_data_valid,
    output logic        fsm_busy,
    output logic        mem_read_en,
    output logic [15:0] memory_address,
    output logic        write_data_array,
    output logic [15:0] fill_word_addr,
    output logic [15:0] fill_data,
    output logic        write_tag_array,
    output logic [11:0] fill_block_addr
);

    // The block geometry is fixed at 16 bytes; latency is the memory's business.
    if (WORDS != 8 || MEM_LAT < 1) begin : g_param_check
        $error("cache_fill_fsm: WORDS must be 8 and MEM_LAT at least 1");
    end

    localparam logic [3:0] ISSUE_MAX = 4'(WORDS);
    localparam logic [2:0] LAST_WORD = 3'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        TAGWR = 2'd2
    } state_t;

    state_t      state, state_next;
    logic [11:0] base, base_next;
    logic [3:0]  issue_cnt, issue_next;
    logic [2:0]  recv_cnt, recv_next;
    logic        unused_offset;

    assign unused_offset = ^miss_address[3:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            base      <= '0;
            issue_cnt <= '0;
            recv_cnt  <= '0;
        end else begin
            state     <= state_next;
            base      <= base_next;
            issue_cnt <= issue_next;
            recv_cnt  <= recv_next;
        end
    end

    always_comb begin
        state_next = state;
        base_next  = base;
        issue_next = issue_cnt;
        recv_next  = recv_cnt;
        unique case (state)
            IDLE: begin
                if (miss_detected) begin
                    base_next  = miss_address[15:4];
                    issue_next = '0;
                    recv_next  = '0;
                    state_next = FILL;
                end
            end
            FILL: begin
                // Requests run ahead of returns; issue_cnt parks at 8 until the block lands.
                if (issue_cnt < ISSUE_MAX) begin
                    issue_next = issue_cnt + 4'd1;
                end
                if (memory_data_valid) begin
                    recv_next = recv_cnt + 3'd1;
                    if (recv_cnt == LAST_WORD) begin
                        state_next = TAGWR;
                    end
                end
            end
            TAGWR: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        fsm_busy         = 1'b0;
        mem_read_en      = 1'b0;
        write_data_array = 1'b0;
        write_tag_array  = 1'b0;
        fill_data        = '0;
        unique case (state)
            FILL: begin
                fsm_busy         = 1'b1;
                mem_read_en      = (issue_cnt < ISSUE_MAX);
                write_data_array = memory_data_valid;
                fill_data        = memory_data;
            end
            TAGWR: begin
                fsm_busy        = 1'b1;
                write_tag_array = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign memory_address  = {base, issue_cnt[2:0], 1'b0};
    assign fill_word_addr  = {base, recv_cnt, 1'b0};
    assign fill_block_addr = base;

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Self-checking bench for cache_fill_fsm: a latency/gap memory model feeds the
// DUT and observed requests, writes and tag strobes are compared per scenario.
module tb_cache_fill_fsm;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic [15:0] memory_data;
    logic        memory_data_valid;
    logic        fsm_busy;
    logic        mem_read_en;
    logic [15:0] memory_address;
    logic        write_data_array;
    logic [15:0] fill_word_addr;
    logic [15:0] fill_data;
    logic        write_tag_array;
    logic [11:0] fill_block_addr;

    cache_fill_fsm #(.WORDS(8), .MEM_LAT(LAT)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .memory_data       (memory_data),
        .memory_data_valid (memory_data_valid),
        .fsm_busy          (fsm_busy),
        .mem_read_en       (mem_read_en),
        .memory_address    (memory_address),
        .write_data_array  (write_data_array),
        .fill_word_addr    (fill_word_addr),
        .fill_data         (fill_data),
        .write_tag_array   (write_tag_array),
        .fill_block_addr   (fill_block_addr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    // Observations of the most recent fill, plus the memory model's schedule.
    logic [15:0] req_addr_q[$];
    int          req_cyc_q[$];
    int          due_q[$];
    logic [15:0] sent_q[$];
    logic [15:0] wr_addr_q[$];
    logic [15:0] wr_data_q[$];
    logic [11:0] tag_q[$];
    int          last_due, tag_cyc, busy_cyc, overlap;
    logic        idle_busy;
    bit          timed_out;

    function automatic logic [15:0] word_addr(input logic [15:0] a, input int i);
        return {a[15:4], 4'h0} + 16'(2 * i);
    endfunction

    // Present a miss in the current (idle) cycle and run the fill to completion.
    // gap<0 picks a random 0..3 cycle gap per word; stop_words>0 returns early
    // at the falling edge where that many data writes have been seen.
    task automatic do_fill(input logic [15:0] addr, input int gap, input logic [15:0] bm_addr,
                           input int bm_from, input int bm_to, input int stop_words);
        int g;
        int nd;
        req_addr_q.delete(); req_cyc_q.delete(); due_q.delete(); sent_q.delete();
        wr_addr_q.delete(); wr_data_q.delete(); tag_q.delete();
        last_due = -100; tag_cyc = -1; busy_cyc = 0; overlap = 0; timed_out = 0;
        miss_detected = 1'b1; miss_address = addr; memory_data_valid = 1'b0;
        @(negedge clk);
        idle_busy = fsm_busy;
        @(posedge clk); #1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            miss_detected = (cyc >= bm_from && cyc <= bm_to);
            miss_address  = miss_detected ? bm_addr : 16'($urandom);
            memory_data   = 16'($urandom);
            if (due_q.size() > 0 && due_q[0] <= cyc) begin
                void'(due_q.pop_front());
                memory_data_valid = 1'b1;
                sent_q.push_back(memory_data);
            end else begin
                memory_data_valid = 1'b0;
            end
            @(negedge clk);
            if (mem_read_en) begin
                req_addr_q.push_back(memory_address);
                req_cyc_q.push_back(cyc);
                g  = (gap < 0) ? int'($urandom_range(3, 0)) : gap;
                nd = cyc + LAT;
                if (last_due + 1 + g > nd) nd = last_due + 1 + g;
                last_due = nd;
                due_q.push_back(nd);
            end
            if (write_data_array) begin
                wr_addr_q.push_back(fill_word_addr);
                wr_data_q.push_back(fill_data);
            end
            if (write_tag_array) begin
                tag_q.push_back(fill_block_addr);
                tag_cyc = cyc;
            end
            if (write_data_array && write_tag_array) overlap++;
            if (fsm_busy) busy_cyc++;
            if (stop_words > 0 && wr_addr_q.size() >= stop_words) return;
            @(posedge clk); #1;
            if (tag_q.size() > 0) break;
        end
        memory_data_valid = 1'b0;
        if (tag_q.size() == 0) timed_out = 1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        miss_detected = 1'b1; miss_address = 16'hABCD;
        memory_data_valid = 1'b1; memory_data = 16'h5555;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (fsm_busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", fsm_busy); else passes++;
        checks++; if (mem_read_en !== 1'b0) $display("FAIL rst_rd_en: got %b want 0", mem_read_en); else passes++;
        checks++; if (write_data_array !== 1'b0) $display("FAIL rst_wda: got %b want 0", write_data_array); else passes++;
        checks++; if (write_tag_array !== 1'b0) $display("FAIL rst_wta: got %b want 0", write_tag_array); else passes++;
        checks++; if (memory_address !== 16'h0) $display("FAIL rst_mem_addr: got %h want 0000", memory_address); else passes++;
        checks++; if (fill_word_addr !== 16'h0) $display("FAIL rst_word_addr: got %h want 0000", fill_word_addr); else passes++;
        checks++; if (fill_block_addr !== 12'h0) $display("FAIL rst_block_addr: got %h want 000", fill_block_addr); else passes++;
        // Miss presented in the first cycle out of reset is taken at the next edge.
        @(posedge clk); #1;
        rst_n = 1'b1; memory_data_valid = 1'b0;
        miss_detected = 1'b1; miss_address = 16'h4448;
        @(negedge clk);
        checks++; if (fsm_busy !== 1'b0) $display("FAIL first_idle_busy: got %b want 0", fsm_busy); else passes++;
        @(posedge clk); #1;
        miss_detected = 1'b0;
        @(negedge clk);
        checks++; if (fsm_busy !== 1'b1) $display("FAIL first_accept_busy: got %b want 1", fsm_busy); else passes++;
        checks++; if (memory_address !== 16'h4440) $display("FAIL first_accept_addr: got %h want 4440", memory_address); else passes++;
        rst_n = 1'b0;
        #1;
        checks++; if (fsm_busy !== 1'b0) $display("FAIL rst_abort_busy: got %b want 0", fsm_busy); else passes++;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        do_fill(16'h1236, 0, 16'h0, -1, -1, 0);
        checks++; if (timed_out) $display("FAIL basic_done: got no tag write want one"); else passes++;
        checks++; if (idle_busy !== 1'b0) $display("FAIL basic_idle_busy: got %b want 0", idle_busy); else passes++;
        checks++; if (req_addr_q.size() != 8) $display("FAIL basic_req_count: got %0d want 8", req_addr_q.size()); else passes++;
        for (int i = 0; i < req_addr_q.size() && i < 8; i++) begin
            checks++; if (req_addr_q[i] !== word_addr(16'h1236, i))
                $display("FAIL basic_req_addr[%0d]: got %h want %h", i, req_addr_q[i], word_addr(16'h1236, i)); else passes++;
            checks++; if (req_cyc_q[i] != i)
                $display("FAIL basic_req_cycle[%0d]: got %0d want %0d", i, req_cyc_q[i], i); else passes++;
        end
        checks++; if (wr_addr_q.size() != 8) $display("FAIL basic_wr_count: got %0d want 8", wr_addr_q.size()); else passes++;
        for (int i = 0; i < wr_addr_q.size() && i < 8 && i < sent_q.size(); i++) begin
            checks++; if (wr_addr_q[i] !== word_addr(16'h1236, i))
                $display("FAIL basic_wr_addr[%0d]: got %h want %h", i, wr_addr_q[i], word_addr(16'h1236, i)); else passes++;
            checks++; if (wr_data_q[i] !== sent_q[i])
                $display("FAIL basic_wr_data[%0d]: got %h want %h", i, wr_data_q[i], sent_q[i]); else passes++;
        end
        checks++; if (tag_q.size() != 1) $display("FAIL basic_tag_count: got %0d want 1", tag_q.size()); else passes++;
        if (tag_q.size() > 0) begin
            checks++; if (tag_q[0] !== 12'h123) $display("FAIL basic_tag_addr: got %h want 123", tag_q[0]); else passes++;
        end
        checks++; if (busy_cyc != 13) $display("FAIL basic_busy_cycles: got %0d want 13", busy_cyc); else passes++;
        checks++; if (overlap != 0) $display("FAIL basic_strobe_overlap: got %0d want 0", overlap); else passes++;
        @(negedge clk);
        checks++; if (fsm_busy !== 1'b0) $display("FAIL basic_end_idle: got %b want 0", fsm_busy); else passes++;
        @(posedge clk); #1;
    endtask

    task automatic test_stall();
        do_fill(16'h2460, 3, 16'h0, -1, -1, 0);
        checks++; if (timed_out) $display("FAIL stall_done: got no tag write want one"); else passes++;
        checks++; if (req_addr_q.size() != 8) $display("FAIL stall_req_count: got %0d want 8", req_addr_q.size()); else passes++;
        if (req_cyc_q.size() == 8) begin
            checks++; if (req_cyc_q[7] != 7) $display("FAIL stall_req_last_cycle: got %0d want 7", req_cyc_q[7]); else passes++;
        end
        checks++; if (wr_addr_q.size() != 8) $display("FAIL stall_wr_count: got %0d want 8", wr_addr_q.size()); else passes++;
        for (int i = 0; i < wr_addr_q.size() && i < 8; i++) begin
            checks++; if (wr_addr_q[i] !== word_addr(16'h2460, i))
                $display("FAIL stall_wr_addr[%0d]: got %h want %h", i, wr_addr_q[i], word_addr(16'h2460, i)); else passes++;
        end
        checks++; if (tag_cyc != LAT + 7 * 4 + 1) $display("FAIL stall_tag_cycle: got %0d want %0d", tag_cyc, LAT + 7 * 4 + 1); else passes++;
        checks++; if (busy_cyc != LAT + 7 * 4 + 2) $display("FAIL stall_busy_cycles: got %0d want %0d", busy_cyc, LAT + 7 * 4 + 2); else passes++;
    endtask

    task automatic test_busy_miss();
        do_fill(16'h1230, 0, 16'h5000, 2, 3, 0);
        checks++; if (timed_out) $display("FAIL busymiss_done: got no tag write want one"); else passes++;
        for (int i = 0; i < req_addr_q.size(); i++) begin
            checks++; if (req_addr_q[i][15:4] !== 12'h123)
                $display("FAIL busymiss_req_addr[%0d]: got %h want 123x", i, req_addr_q[i]); else passes++;
        end
        if (tag_q.size() > 0) begin
            checks++; if (tag_q[0] !== 12'h123) $display("FAIL busymiss_tag_addr: got %h want 123", tag_q[0]); else passes++;
        end
        @(negedge clk);
        checks++; if (fsm_busy !== 1'b0) $display("FAIL busymiss_no_queue: got %b want 0", fsm_busy); else passes++;
        @(posedge clk); #1;
    endtask

    task automatic test_spurious_valid();
        miss_detected = 1'b0;
        for (int i = 0; i < 4; i++) begin
            memory_data_valid = 1'b1; memory_data = 16'($urandom);
            @(negedge clk);
            checks++; if (write_data_array !== 1'b0) $display("FAIL spurious_wda[%0d]: got %b want 0", i, write_data_array); else passes++;
            checks++; if (fsm_busy !== 1'b0) $display("FAIL spurious_busy[%0d]: got %b want 0", i, fsm_busy); else passes++;
            @(posedge clk); #1;
        end
        memory_data_valid = 1'b0;
    endtask

    task automatic test_reset_mid_fill();
        do_fill(16'h2340, 0, 16'h0, -1, -1, 3);
        checks++; if (wr_addr_q.size() != 3) $display("FAIL midrst_words: got %0d want 3", wr_addr_q.size()); else passes++;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (fsm_busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", fsm_busy); else passes++;
        checks++; if (mem_read_en !== 1'b0) $display("FAIL midrst_rd_en: got %b want 0", mem_read_en); else passes++;
        checks++; if (write_data_array !== 1'b0) $display("FAIL midrst_wda: got %b want 0", write_data_array); else passes++;
        checks++; if (memory_address !== 16'h0) $display("FAIL midrst_mem_addr: got %h want 0000", memory_address); else passes++;
        checks++; if (fill_block_addr !== 12'h0) $display("FAIL midrst_block_addr: got %h want 000", fill_block_addr); else passes++;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++; if (write_tag_array !== 1'b0) $display("FAIL midrst_no_tag[%0d]: got %b want 0", i, write_tag_array); else passes++;
        end
        @(posedge clk); #1;
        rst_n = 1'b1; memory_data_valid = 1'b0; miss_detected = 1'b0;
        do_fill(16'hFFF0, 0, 16'h0, -1, -1, 0);
        checks++; if (timed_out) $display("FAIL postrst_done: got no tag write want one"); else passes++;
        checks++; if (req_addr_q.size() != 8) $display("FAIL postrst_req_count: got %0d want 8", req_addr_q.size()); else passes++;
        for (int i = 0; i < wr_addr_q.size() && i < 8 && i < sent_q.size(); i++) begin
            checks++; if (wr_addr_q[i] !== word_addr(16'hFFF0, i))
                $display("FAIL postrst_wr_addr[%0d]: got %h want %h", i, wr_addr_q[i], word_addr(16'hFFF0, i)); else passes++;
            checks++; if (wr_data_q[i] !== sent_q[i])
                $display("FAIL postrst_wr_data[%0d]: got %h want %h", i, wr_data_q[i], sent_q[i]); else passes++;
        end
        if (tag_q.size() > 0) begin
            checks++; if (tag_q[0] !== 12'hFFF) $display("FAIL postrst_tag_addr: got %h want fff", tag_q[0]); else passes++;
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] first_tag;
        do_fill(16'h0000, 0, 16'h0010, 0, 100000, 0);
        first_tag = (tag_q.size() > 0) ? tag_q[0] : 12'hxxx;
        checks++; if (first_tag !== 12'h000) $display("FAIL b2b_tag0: got %h want 000", first_tag); else passes++;
        checks++; if (busy_cyc != 13) $display("FAIL b2b_busy0: got %0d want 13", busy_cyc); else passes++;
        do_fill(16'h0010, 0, 16'h0010, 0, 100000, 0);
        miss_detected = 1'b0;
        checks++; if (idle_busy !== 1'b0) $display("FAIL b2b_gap_idle: got %b want 0", idle_busy); else passes++;
        checks++; if (req_cyc_q.size() == 0 || req_cyc_q[0] != 0)
            $display("FAIL b2b_second_start: got %0d requests want first at cycle 0", req_cyc_q.size()); else passes++;
        checks++; if (tag_q.size() != 1 || tag_q[0] !== 12'h001)
            $display("FAIL b2b_tag1: got %0d tags first %h want 1 tag 001", tag_q.size(), (tag_q.size() > 0) ? tag_q[0] : 12'h0); else passes++;
        checks++; if (busy_cyc != 13) $display("FAIL b2b_busy1: got %0d want 13", busy_cyc); else passes++;
    endtask

    task automatic test_random();
        logic [15:0] a;
        int from;
        for (int n = 0; n < 6; n++) begin
            a    = 16'($urandom);
            from = int'($urandom_range(10, 0));
            do_fill(a, -1, 16'($urandom), from, from + int'($urandom_range(3, 0)), 0);
            checks++; if (timed_out) $display("FAIL rand%0d_done: got no tag write want one", n); else passes++;
            checks++; if (req_addr_q.size() != 8) $display("FAIL rand%0d_req_count: got %0d want 8", n, req_addr_q.size()); else passes++;
            for (int i = 0; i < req_addr_q.size() && i < 8; i++) begin
                checks++; if (req_addr_q[i] !== word_addr(a, i))
                    $display("FAIL rand%0d_req_addr[%0d]: got %h want %h", n, i, req_addr_q[i], word_addr(a, i)); else passes++;
            end
            checks++; if (wr_addr_q.size() != 8) $display("FAIL rand%0d_wr_count: got %0d want 8", n, wr_addr_q.size()); else passes++;
            for (int i = 0; i < wr_addr_q.size() && i < 8 && i < sent_q.size(); i++) begin
                checks++; if (wr_addr_q[i] !== word_addr(a, i) || wr_data_q[i] !== sent_q[i])
                    $display("FAIL rand%0d_wr[%0d]: got %h/%h want %h/%h", n, i, wr_addr_q[i], wr_data_q[i], word_addr(a, i), sent_q[i]); else passes++;
            end
            checks++; if (tag_q.size() != 1 || tag_q[0] !== a[15:4])
                $display("FAIL rand%0d_tag: got %0d tags first %h want 1 tag %h", n, tag_q.size(), (tag_q.size() > 0) ? tag_q[0] : 12'h0, a[15:4]); else passes++;
            checks++; if (busy_cyc != last_due + 2) $display("FAIL rand%0d_busy: got %0d want %0d", n, busy_cyc, last_due + 2); else passes++;
            checks++; if (overlap != 0) $display("FAIL rand%0d_overlap: got %0d want 0", n, overlap); else passes++;
        end
        miss_detected = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got simulation still running want finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; miss_detected = 1'b0; miss_address = '0;
        memory_data = '0; memory_data_valid = 1'b0;
        test_reset();
        test_basic();
        test_stall();
        test_busy_miss();
        test_spurious_valid();
        test_reset_mid_fill();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
